alu_exec_ctrl: RTL and testbench

Multi-cycle execute sequencer for the integer ALU datapath of the simple processor. It accepts one decoded instruction at a time over a valid/ready handshake and reads rs1/rs2 through a single shared register-file read port. It then drives the ALU operand, function and immediate inputs, registers the result and writes it back to the register file. It also keeps a retired-instruction count and flags unsupported functions.

---
 rtl/alu_exec_ctrl_pkg.sv | 27 ++
 rtl/alu_exec_ctrl_if.sv | 44 ++++
 rtl/alu_exec_ctrl.sv | 115 +++++++++++
 tb/tb_alu_exec_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_ctrl_pkg.sv
// Shared types for the simple processor execute stage: widths, ALU function
// encodings and the execute sequencer state encoding.
package simple_processor_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int REG_ADDR_W = 5;
    localparam int IMM_W      = 6;

    typedef enum logic [2:0] {
        ADD  = 3'd0,
        SUB  = 3'd1,
        ADDI = 3'd2
    } func_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        EXEC = 3'd3,
        WB   = 3'd4
    } exec_state_t;

    function automatic logic func_legal(func_t f);
        return (f == ADD) || (f == SUB) || (f == ADDI);
    endfunction

endpackage

// File: rtl/alu_exec_ctrl_if.sv
// Instruction handshake, register-file and ALU buses of the execute sequencer.
// The slave modport is the sequencer; master is its surroundings.
interface alu_exec_ctrl_if;
    import simple_processor_pkg::*;

    logic                  instr_valid_i;
    logic                  instr_ready_o;
    func_t                 instr_func_i;
    logic [REG_ADDR_W-1:0] instr_rd_i;
    logic [REG_ADDR_W-1:0] instr_rs1_i;
    logic [REG_ADDR_W-1:0] instr_rs2_i;
    logic [IMM_W-1:0]      instr_imm_i;
    logic [REG_ADDR_W-1:0] rf_raddr_o;
    logic [DATA_WIDTH-1:0] rf_rdata_i;
    logic [DATA_WIDTH-1:0] alu_rs1_data_o;
    logic [DATA_WIDTH-1:0] alu_rs2_data_o;
    func_t                 alu_func_o;
    logic [IMM_W-1:0]      alu_imm_o;
    logic [DATA_WIDTH-1:0] alu_result_i;
    logic                  rf_we_o;
    logic [REG_ADDR_W-1:0] rf_waddr_o;
    logic [DATA_WIDTH-1:0] rf_wdata_o;
    logic                  retire_o;
    logic                  illegal_o;
    logic                  busy_o;
    logic [31:0]           retired_cnt_o;

    modport slave (
        input  instr_valid_i, instr_func_i, instr_rd_i, instr_rs1_i, instr_rs2_i,
               instr_imm_i, rf_rdata_i, alu_result_i,
        output instr_ready_o, rf_raddr_o, alu_rs1_data_o, alu_rs2_data_o, alu_func_o,
               alu_imm_o, rf_we_o, rf_waddr_o, rf_wdata_o, retire_o, illegal_o,
               busy_o, retired_cnt_o
    );

    modport master (
        output instr_valid_i, instr_func_i, instr_rd_i, instr_rs1_i, instr_rs2_i,
               instr_imm_i, rf_rdata_i, alu_result_i,
        input  instr_ready_o, rf_raddr_o, alu_rs1_data_o, alu_rs2_data_o, alu_func_o,
               alu_imm_o, rf_we_o, rf_waddr_o, rf_wdata_o, retire_o, illegal_o,
               busy_o, retired_cnt_o
    );

endinterface

// File: rtl/alu_exec_ctrl.sv
// Multi-cycle execute sequencer: reads rs1/rs2 over one shared RF read port,
// presents registered operands to the ALU, captures the result and writes back.
module alu_exec_ctrl
    import simple_processor_pkg::*;
(
    input  logic           clk_i,
    input  logic           arst_i,
    alu_exec_ctrl_if.slave bus
);

    exec_state_t           state_q, state_d;
    func_t                 func_q, func_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [REG_ADDR_W-1:0] rs1_q, rs1_d;
    logic [REG_ADDR_W-1:0] rs2_q, rs2_d;
    logic [IMM_W-1:0]      imm_q, imm_d;
    logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
    logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic                  illegal_q, illegal_d;
    logic [31:0]           retired_cnt_q, retired_cnt_d;
    logic                  accept;

    assign accept = (state_q == IDLE) && bus.instr_valid_i;

    always_comb begin
        state_d       = state_q;
        func_d        = func_q;
        rd_d          = rd_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        imm_d         = imm_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        res_d         = res_q;
        illegal_d     = 1'b0;
        retired_cnt_d = retired_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    func_d    = bus.instr_func_i;
                    rd_d      = bus.instr_rd_i;
                    rs1_d     = bus.instr_rs1_i;
                    rs2_d     = bus.instr_rs2_i;
                    imm_d     = bus.instr_imm_i;
                    // Illegal functions are reported and dropped without touching the RF.
                    illegal_d = !func_legal(bus.instr_func_i);
                    state_d   = func_legal(bus.instr_func_i) ? RD_A : IDLE;
                end
            end
            RD_A: begin
                op_a_d  = bus.rf_rdata_i;
                state_d = (func_q == ADDI) ? EXEC : RD_B;
            end
            RD_B: begin
                op_b_d  = bus.rf_rdata_i;
                state_d = EXEC;
            end
            EXEC: begin
                res_d   = bus.alu_result_i;
                state_d = WB;
            end
            WB: begin
                retired_cnt_d = retired_cnt_q + 32'd1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q       <= IDLE;
            func_q        <= ADD;
            rd_q          <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            imm_q         <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            res_q         <= '0;
            illegal_q     <= 1'b0;
            retired_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            func_q        <= func_d;
            rd_q          <= rd_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            imm_q         <= imm_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            res_q         <= res_d;
            illegal_q     <= illegal_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    assign bus.instr_ready_o  = (state_q == IDLE);
    assign bus.busy_o         = (state_q != IDLE);
    assign bus.rf_raddr_o     = (state_q == RD_A) ? rs1_q :
                                (state_q == RD_B) ? rs2_q : '0;
    assign bus.alu_rs1_data_o = op_a_q;
    assign bus.alu_rs2_data_o = op_b_q;
    assign bus.alu_func_o     = func_q;
    assign bus.alu_imm_o      = imm_q;
    // r0 is hardwired to zero, so its writes are dropped but the op still retires.
    assign bus.rf_we_o        = (state_q == WB) && (rd_q != '0);
    assign bus.rf_waddr_o     = rd_q;
    assign bus.rf_wdata_o     = res_q;
    assign bus.retire_o       = (state_q == WB);
    assign bus.illegal_o      = illegal_q;
    assign bus.retired_cnt_o  = retired_cnt_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a behavioural register file and ALU.
module tb_alu_exec_ctrl;
    import simple_processor_pkg::*;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    logic [31:0] rf [32];
    int          wr_cnt;
    logic [4:0]  last_waddr;
    logic [31:0] last_wdata;
    logic [31:0] acc_mask;

    alu_exec_ctrl_if bus ();

    alu_exec_ctrl dut (
        .clk_i  (clk),
        .arst_i (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb bus.rf_rdata_i = rf[bus.rf_raddr_o];

    always_comb begin
        logic [31:0] sext;
        sext = {{26{bus.alu_imm_o[5]}}, bus.alu_imm_o};
        case (bus.alu_func_o)
            SUB:     bus.alu_result_i = bus.alu_rs1_data_o - bus.alu_rs2_data_o;
            ADDI:    bus.alu_result_i = bus.alu_rs1_data_o + sext;
            default: bus.alu_result_i = bus.alu_rs1_data_o + bus.alu_rs2_data_o;
        endcase
    end

    always @(posedge clk) begin
        if (bus.rf_we_o) begin
            wr_cnt     <= wr_cnt + 1;
            last_waddr <= bus.rf_waddr_o;
            last_wdata <= bus.rf_wdata_o;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction while idle; returns one step after the accept edge (cycle 1).
    task automatic issue(input func_t f, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [5:0] imm);
        bus.instr_func_i  = f;
        bus.instr_rd_i    = rd;
        bus.instr_rs1_i   = rs1;
        bus.instr_rs2_i   = rs2;
        bus.instr_imm_i   = imm;
        bus.instr_valid_i = 1'b1;
        tick();
        bus.instr_valid_i = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        wr_cnt = 0;
        last_waddr = '0;
        last_wdata = '0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rf[1]  = 32'd5;
        rf[2]  = 32'd7;
        rf[6]  = 32'hDEAD;
        rf[10] = 32'd10;
        bus.instr_valid_i = 1'b0;
        bus.instr_func_i  = ADD;
        bus.instr_rd_i    = '0;
        bus.instr_rs1_i   = '0;
        bus.instr_rs2_i   = '0;
        bus.instr_imm_i   = '0;

        rst = 1'b1;
        #12;
        chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("rst_cnt", bus.retired_cnt_o, 32'd0);
        chk("rst_we", {31'd0, bus.rf_we_o}, 32'd0);
        chk("rst_func", {29'd0, bus.alu_func_o}, 32'd0);
        chk("rst_opa", bus.alu_rs1_data_o, 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_ready", {31'd0, bus.instr_ready_o}, 32'd1);

        // ADD r3 = r1 + r2
        issue(ADD, 5'd3, 5'd1, 5'd2, 6'd0);
        chk("add_c1_raddr", {27'd0, bus.rf_raddr_o}, 32'd1);
        chk("add_c1_ready", {31'd0, bus.instr_ready_o}, 32'd0);
        tick();
        chk("add_c2_raddr", {27'd0, bus.rf_raddr_o}, 32'd2);
        tick();
        chk("add_c3_raddr", {27'd0, bus.rf_raddr_o}, 32'd0);
        chk("add_c3_opa", bus.alu_rs1_data_o, 32'd5);
        chk("add_c3_opb", bus.alu_rs2_data_o, 32'd7);
        chk("add_c3_we", {31'd0, bus.rf_we_o}, 32'd0);
        tick();
        chk("add_c4_we", {31'd0, bus.rf_we_o}, 32'd1);
        chk("add_c4_waddr", {27'd0, bus.rf_waddr_o}, 32'd3);
        chk("add_c4_wdata", bus.rf_wdata_o, 32'd12);
        chk("add_c4_retire", {31'd0, bus.retire_o}, 32'd1);
        tick();
        chk("add_c5_ready", {31'd0, bus.instr_ready_o}, 32'd1);
        chk("add_c5_retire", {31'd0, bus.retire_o}, 32'd0);
        chk("add_cnt", bus.retired_cnt_o, 32'd1);

        // SUB r4 = r1 - r2
        issue(SUB, 5'd4, 5'd1, 5'd2, 6'd0);
        chk("sub_c1_raddr", {27'd0, bus.rf_raddr_o}, 32'd1);
        tick();
        chk("sub_c2_raddr", {27'd0, bus.rf_raddr_o}, 32'd2);
        tick();
        tick();
        chk("sub_c4_we", {31'd0, bus.rf_we_o}, 32'd1);
        chk("sub_c4_wdata", bus.rf_wdata_o, 32'hFFFF_FFFE);
        tick();
        chk("sub_cnt", bus.retired_cnt_o, 32'd2);

        // ADDI r5 = r10 + (-1); rs2 field must never be read
        issue(ADDI, 5'd5, 5'd10, 5'd2, 6'b111111);
        chk("addi_c1_raddr", {27'd0, bus.rf_raddr_o}, 32'd10);
        tick();
        chk("addi_c2_raddr", {27'd0, bus.rf_raddr_o}, 32'd0);
        chk("addi_c2_busy", {31'd0, bus.busy_o}, 32'd1);
        tick();
        chk("addi_c3_we", {31'd0, bus.rf_we_o}, 32'd1);
        chk("addi_c3_waddr", {27'd0, bus.rf_waddr_o}, 32'd5);
        chk("addi_c3_wdata", bus.rf_wdata_o, 32'd9);
        tick();
        chk("addi_c4_ready", {31'd0, bus.instr_ready_o}, 32'd1);
        chk("addi_cnt", bus.retired_cnt_o, 32'd3);

        // ADD to r0: retires without writing
        issue(ADD, 5'd0, 5'd1, 5'd2, 6'd0);
        tick();
        tick();
        tick();
        chk("r0_c4_we", {31'd0, bus.rf_we_o}, 32'd0);
        chk("r0_c4_retire", {31'd0, bus.retire_o}, 32'd1);
        tick();
        chk("r0_cnt", bus.retired_cnt_o, 32'd4);
        chk("r0_wr_cnt", wr_cnt, 32'd3);

        // Illegal function
        issue(func_t'(3'd5), 5'd7, 5'd1, 5'd2, 6'd0);
        chk("ill_c1_pulse", {31'd0, bus.illegal_o}, 32'd1);
        chk("ill_c1_ready", {31'd0, bus.instr_ready_o}, 32'd1);
        chk("ill_c1_raddr", {27'd0, bus.rf_raddr_o}, 32'd0);
        tick();
        chk("ill_c2_pulse", {31'd0, bus.illegal_o}, 32'd0);
        chk("ill_cnt", bus.retired_cnt_o, 32'd4);
        chk("ill_wr_cnt", wr_cnt, 32'd3);

        // Reset during EXEC aborts the instruction
        issue(ADD, 5'd6, 5'd1, 5'd2, 6'd0);
        tick();
        tick();
        chk("rex_busy_pre", {31'd0, bus.busy_o}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rex_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("rex_cnt", bus.retired_cnt_o, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("rex_ready", {31'd0, bus.instr_ready_o}, 32'd1);
        for (int i = 0; i < 4; i++) tick();
        chk("rex_wr_cnt", wr_cnt, 32'd3);
        chk("rex_cnt_after", bus.retired_cnt_o, 32'd0);

        // Valid held high: three back-to-back ADDs
        bus.instr_func_i  = ADD;
        bus.instr_rd_i    = 5'd8;
        bus.instr_rs1_i   = 5'd1;
        bus.instr_rs2_i   = 5'd2;
        bus.instr_valid_i = 1'b1;
        acc_mask = '0;
        for (int c = 0; c < 15; c++) begin
            if (c == 14) bus.instr_valid_i = 1'b0;
            if (bus.instr_valid_i && bus.instr_ready_o) acc_mask[c] = 1'b1;
            tick();
        end
        bus.instr_valid_i = 1'b0;
        chk("q_accept_mask", acc_mask, 32'h0000_0421);
        chk("q_cnt", bus.retired_cnt_o, 32'd3);
        chk("q_wr_cnt", wr_cnt, 32'd6);
        chk("q_wdata", last_wdata, 32'd12);

        // Counter wrap
        force dut.retired_cnt_q = 32'hFFFF_FFFF;
        tick();
        release dut.retired_cnt_q;
        tick();
        chk("wrap_preset", bus.retired_cnt_o, 32'hFFFF_FFFF);
        issue(ADDI, 5'd9, 5'd10, 5'd0, 6'd1);
        tick();
        tick();
        tick();
        chk("wrap_cnt", bus.retired_cnt_o, 32'd0);
        chk("wrap_waddr", {27'd0, last_waddr}, 32'd9);
        chk("wrap_wdata", last_wdata, 32'd11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
